// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LONG = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - operand forwarding select for one ID source
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_use,
  input  logic                  i_ex_v,
  input  logic                  i_ex_rw,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_wb_v,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  output logic [1:0]            o_sel
);

  logic w_ex_hit;
  logic w_wb_hit;

  // EX holds the younger write, so it must win over WB.
  assign w_ex_hit = i_use && i_ex_v && i_ex_rw && (i_ex_rd == i_src);
  assign w_wb_hit = i_use && i_wb_v && (i_wb_rd == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit)      o_sel = FWD_EX;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline freeze, bubble and forwarding controller
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_if_id_valid,
  input  logic [REG_ADDR_W-1:0]  i_id_rs1,
  input  logic [REG_ADDR_W-1:0]  i_id_rs2,
  input  logic                   i_id_uses_rs1,
  input  logic                   i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]  i_id_rd,
  input  logic                   i_id_reg_write,
  input  logic                   i_id_alu_op,
  input  logic                   i_ext_hold,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic                   o_ex_hold,
  output logic                   o_bubble,
  output logic [1:0]             o_fwd_sel1,
  output logic [1:0]             o_fwd_sel2,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
);

  state_e                  r_state;
  logic                    r_ex_v;
  logic                    r_ex_rw;
  logic [REG_ADDR_W-1:0]   r_ex_rd;
  logic                    r_ex_long;
  logic                    r_wb_v;
  logic [REG_ADDR_W-1:0]   r_wb_rd;
  logic                    r_flush_pend;
  logic [STALL_CNT_W-1:0]  r_stall_cycles;

  logic w_long_freeze;
  logic w_freeze;
  logic w_bubble;

  // A long op freezes only on its first EX cycle; LONG state marks the second.
  assign w_long_freeze = (r_state == ST_RUN) && r_ex_v && r_ex_long;
  assign w_freeze      = i_ext_hold || w_long_freeze;
  assign w_bubble      = !w_freeze && (i_flush || r_flush_pend || !i_if_id_valid);

  assign o_stall        = w_freeze;
  assign o_ex_hold      = w_freeze;
  assign o_bubble       = w_bubble;
  assign o_stall_cycles = r_stall_cycles;

  fwd_select u_fwd1 (
    .i_src   (i_id_rs1),
    .i_use   (i_id_uses_rs1),
    .i_ex_v  (r_ex_v),
    .i_ex_rw (r_ex_rw),
    .i_ex_rd (r_ex_rd),
    .i_wb_v  (r_wb_v),
    .i_wb_rd (r_wb_rd),
    .o_sel   (o_fwd_sel1)
  );

  fwd_select u_fwd2 (
    .i_src   (i_id_rs2),
    .i_use   (i_id_uses_rs2),
    .i_ex_v  (r_ex_v),
    .i_ex_rw (r_ex_rw),
    .i_ex_rd (r_ex_rd),
    .i_wb_v  (r_wb_v),
    .i_wb_rd (r_wb_rd),
    .o_sel   (o_fwd_sel2)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else if (!i_ext_hold) begin
      if (w_long_freeze)          r_state <= ST_LONG;
      else if (r_state == ST_LONG) r_state <= ST_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_v    <= 1'b0;
      r_ex_rw   <= 1'b0;
      r_ex_rd   <= '0;
      r_ex_long <= 1'b0;
      r_wb_v    <= 1'b0;
      r_wb_rd   <= '0;
    end else if (i_ext_hold) begin
      r_ex_v <= r_ex_v;
    end else if (w_long_freeze) begin
      r_wb_v <= 1'b0;
    end else begin
      r_wb_v  <= r_ex_v && r_ex_rw;
      r_wb_rd <= r_ex_rd;
      if (!w_bubble) begin
        r_ex_v    <= 1'b1;
        r_ex_rw   <= i_id_reg_write;
        r_ex_rd   <= i_id_rd;
        r_ex_long <= i_id_alu_op;
      end else begin
        r_ex_v <= 1'b0;
      end
    end
  end

  // A flush seen while frozen is remembered until the first unfrozen edge.
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_flush_pend <= 1'b0;
    else if (w_freeze) r_flush_pend <= r_flush_pend || i_flush;
    else               r_flush_pend <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_stall_cycles <= '0;
    else if (w_freeze && (r_stall_cycles != {STALL_CNT_W{1'b1}}))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end

endmodule
